// File: rtl/csr_wr_sequencer_pkg.sv
// Shared types and sizing for the CSR write sequencer.
// Default widths stand in when the surrounding core does not define its own macros.
`ifndef SIZE_ACTIVELIST_LOG
`define SIZE_ACTIVELIST_LOG 5
`endif
`ifndef CSR_WIDTH
`define CSR_WIDTH 32
`endif
`ifndef CSR_WIDTH_LOG
`define CSR_WIDTH_LOG 12
`endif

package csr_wr_sequencer_pkg;
  localparam int CSR_WR_DEPTH = 4;
  localparam int CSR_AL_ID_W  = `SIZE_ACTIVELIST_LOG;
  localparam int CSR_DATA_W   = `CSR_WIDTH;
  localparam int CSR_ADDR_W   = `CSR_WIDTH_LOG;

  typedef struct packed {
    logic [CSR_ADDR_W-1:0]  addr;
    logic [CSR_DATA_W-1:0]  data;
    logic [CSR_AL_ID_W-1:0] alId;
  } csr_wr_entry_t;

  // One extra MSB distinguishes full from empty when indices coincide.
  function automatic int csr_wr_ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/csr_wr_fwd_match.sv
// Youngest-match select over the committed, undrained window [head, cptr).
// Only instantiated when CSR_WR_FWD_EN is defined.
module csr_wr_fwd_match
  import csr_wr_sequencer_pkg::*;
#(
  parameter int DEPTH = CSR_WR_DEPTH,
  parameter int PTR_W = csr_wr_ptr_width(CSR_WR_DEPTH)
) (
  input  logic [PTR_W-1:0]      head,
  input  logic [PTR_W-1:0]      cptr,
  input  csr_wr_entry_t         entry_mem [DEPTH],
  input  logic [CSR_ADDR_W-1:0] rd_addr,
  output logic                  hit,
  output logic [CSR_DATA_W-1:0] data
);
  localparam int IDX_W = PTR_W - 1;

  logic [PTR_W-1:0]      window;
  logic [DEPTH-1:0]      match_vec;
  logic [CSR_DATA_W-1:0] data_vec [DEPTH];

  assign window = cptr - head;

  // Slot gi is the gi-th oldest entry counted from head.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [IDX_W-1:0] idx;
    assign idx           = head[IDX_W-1:0] + IDX_W'(gi);
    assign match_vec[gi] = (PTR_W'(gi) < window) && (entry_mem[idx].addr == rd_addr);
    assign data_vec[gi]  = entry_mem[idx].data;
  end

  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match_vec[i]) begin
        hit  = 1'b1;
        data = data_vec[i];
      end
    end
  end
endmodule

// File: rtl/csr_wr_sequencer.sv
// Buffers speculative CSR writes and releases them in program order after commit.
// Optional store-to-load forwarding of committed writes under CSR_WR_FWD_EN.
module csr_wr_sequencer
  import csr_wr_sequencer_pkg::*;
#(
  parameter int DEPTH = CSR_WR_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   exeWrEn_i,
  input  logic [CSR_ADDR_W-1:0]  exeWrAddr_i,
  input  logic [CSR_DATA_W-1:0]  exeWrData_i,
  input  logic [CSR_AL_ID_W-1:0] exeAlId_i,
  output logic                   full_o,
  input  logic                   commitValid_i,
  input  logic [CSR_AL_ID_W-1:0] commitAlId_i,
  input  logic                   flush_i,
  output logic                   csrWrEn_o,
  output logic [CSR_ADDR_W-1:0]  csrWrAddr_o,
  output logic [CSR_DATA_W-1:0]  csrWrData_o,
  input  logic                   csrWrReady_i,
  output logic                   pending_o,
  output logic                   err_o
`ifdef CSR_WR_FWD_EN
  ,
  input  logic [CSR_ADDR_W-1:0]  csrRdAddr_i,
  output logic                   fwdHit_o,
  output logic [CSR_DATA_W-1:0]  fwdData_o
`endif
);
  localparam int PTR_W = csr_wr_ptr_width(DEPTH);
  localparam int IDX_W = PTR_W - 1;

  logic [PTR_W-1:0] head_reg, cptr_reg, tail_reg;
  logic [PTR_W-1:0] head_next, cptr_next, tail_next;
  logic             err_reg, err_next;
  logic             do_enq, do_commit, do_drain;
  csr_wr_entry_t    entry_mem [DEPTH];
  csr_wr_entry_t    head_entry;

  assign full_o     = (tail_reg - head_reg) == PTR_W'(DEPTH);
  assign csrWrEn_o  = (head_reg != cptr_reg);
  assign pending_o  = csrWrEn_o;
  assign err_o      = err_reg;
  assign head_entry = entry_mem[head_reg[IDX_W-1:0]];
  // Gate with the valid so stale slots never appear on the write bus.
  assign csrWrAddr_o = csrWrEn_o ? head_entry.addr : '0;
  assign csrWrData_o = csrWrEn_o ? head_entry.data : '0;

  always_comb begin
    do_enq    = exeWrEn_i && !full_o && !flush_i;
    do_commit = commitValid_i && (cptr_reg != tail_reg) &&
                (entry_mem[cptr_reg[IDX_W-1:0]].alId == commitAlId_i);
    do_drain  = csrWrEn_o && csrWrReady_i;
    err_next  = err_reg || (commitValid_i && !do_commit) ||
                (exeWrEn_i && full_o && !flush_i);
    head_next = head_reg + PTR_W'(do_drain);
    cptr_next = cptr_reg + PTR_W'(do_commit);
    tail_next = tail_reg + PTR_W'(do_enq);
    // Recovery keeps everything up to and including a same-cycle commit.
    if (flush_i) begin
      tail_next = cptr_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_reg <= '0;
      cptr_reg <= '0;
      tail_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      head_reg <= head_next;
      cptr_reg <= cptr_next;
      tail_reg <= tail_next;
      err_reg  <= err_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) begin
      entry_mem[tail_reg[IDX_W-1:0]] <= '{addr: exeWrAddr_i, data: exeWrData_i, alId: exeAlId_i};
    end
  end

`ifdef CSR_WR_FWD_EN
  csr_wr_fwd_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fwd (
    .head      (head_reg),
    .cptr      (cptr_reg),
    .entry_mem (entry_mem),
    .rd_addr   (csrRdAddr_i),
    .hit       (fwdHit_o),
    .data      (fwdData_o)
  );
`else
  // Without forwarding, CSR readers stall on pending_o instead.
`endif
endmodule

// File: tb/tb_csr_wr_sequencer.sv
// Scoreboard bench for csr_wr_sequencer: queue-level model of speculative and committed writes.
// Forwarding checks are compiled in when CSR_WR_FWD_EN is defined.
module tb_csr_wr_sequencer;
  import csr_wr_sequencer_pkg::*;
  localparam int DEPTH = CSR_WR_DEPTH;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic                   exeWrEn_i = 1'b0;
  logic [CSR_ADDR_W-1:0]  exeWrAddr_i = '0;
  logic [CSR_DATA_W-1:0]  exeWrData_i = '0;
  logic [CSR_AL_ID_W-1:0] exeAlId_i = '0;
  logic                   full_o;
  logic                   commitValid_i = 1'b0;
  logic [CSR_AL_ID_W-1:0] commitAlId_i = '0;
  logic                   flush_i = 1'b0;
  logic                   csrWrEn_o;
  logic [CSR_ADDR_W-1:0]  csrWrAddr_o;
  logic [CSR_DATA_W-1:0]  csrWrData_o;
  logic                   csrWrReady_i = 1'b0;
  logic                   pending_o;
  logic                   err_o;
`ifdef CSR_WR_FWD_EN
  logic [CSR_ADDR_W-1:0]  csrRdAddr_i = '0;
  logic                   fwdHit_o;
  logic [CSR_DATA_W-1:0]  fwdData_o;
`endif

  csr_wr_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .exeWrEn_i(exeWrEn_i), .exeWrAddr_i(exeWrAddr_i), .exeWrData_i(exeWrData_i), .exeAlId_i(exeAlId_i),
    .full_o(full_o), .commitValid_i(commitValid_i), .commitAlId_i(commitAlId_i), .flush_i(flush_i),
    .csrWrEn_o(csrWrEn_o), .csrWrAddr_o(csrWrAddr_o), .csrWrData_o(csrWrData_o),
    .csrWrReady_i(csrWrReady_i), .pending_o(pending_o), .err_o(err_o)
`ifdef CSR_WR_FWD_EN
    , .csrRdAddr_i(csrRdAddr_i), .fwdHit_o(fwdHit_o), .fwdData_o(fwdData_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CSR_ADDR_W-1:0]  addr;
    logic [CSR_DATA_W-1:0]  data;
    logic [CSR_AL_ID_W-1:0] id;
  } wr_t;

  wr_t spec_q[$];   // enqueued, not yet committed (program order)
  wr_t exp_q[$];    // committed, awaiting drain: the scoreboard
  bit  m_err = 1'b0;
  bit  mon_en = 1'b1;
  int  checks = 0;
  int  errors = 0;
  int  next_id = 0;

  function automatic void check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Monitor: every accepted write must match the oldest committed entry.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en && reset_n && csrWrEn_o && csrWrReady_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", longint'(csrWrAddr_o), -1);
        end else begin
          $display("WR addr=%0h data=%0h (expect addr=%0h data=%0h id=%0d)",
                   csrWrAddr_o, csrWrData_o, exp_q[0].addr, exp_q[0].data, exp_q[0].id);
          check("wr_addr", longint'(csrWrAddr_o), longint'(exp_q[0].addr));
          check("wr_data", longint'(csrWrData_o), longint'(exp_q[0].data));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // One cycle: check state-level outputs against the model, then drive and advance the model.
  task automatic step(input bit en, input int unsigned a, input int unsigned d, input int unsigned id,
                      input bit cv, input int unsigned cid, input bit fl, input bit rdy);
    bit  full_m;
    wr_t w;
    @(negedge clk);
    full_m = (spec_q.size() + exp_q.size()) >= DEPTH;
    check("full", longint'(full_o), longint'(full_m));
    check("err", longint'(err_o), longint'(m_err));
    check("wr_en", longint'(csrWrEn_o), longint'(exp_q.size() != 0));
    check("pending", longint'(pending_o), longint'(exp_q.size() != 0));
`ifdef CSR_WR_FWD_EN
    begin
      bit hit_m = 1'b0;
      logic [CSR_DATA_W-1:0] data_m = '0;
      foreach (exp_q[k]) if (exp_q[k].addr == csrRdAddr_i) begin hit_m = 1'b1; data_m = exp_q[k].data; end
      check("fwd_hit", longint'(fwdHit_o), longint'(hit_m));
      if (hit_m) check("fwd_data", longint'(fwdData_o), longint'(data_m));
    end
`endif
    #1;
    exeWrEn_i     = en;
    exeWrAddr_i   = CSR_ADDR_W'(a);
    exeWrData_i   = CSR_DATA_W'(d);
    exeAlId_i     = CSR_AL_ID_W'(id);
    commitValid_i = cv;
    commitAlId_i  = CSR_AL_ID_W'(cid);
    flush_i       = fl;
    csrWrReady_i  = rdy;
`ifdef CSR_WR_FWD_EN
    csrRdAddr_i   = CSR_ADDR_W'($urandom_range(0, 7));
`endif
    if (cv) begin
      if (spec_q.size() != 0 && spec_q[0].id == CSR_AL_ID_W'(cid)) exp_q.push_back(spec_q.pop_front());
      else m_err = 1'b1;
    end
    if (fl) begin
      spec_q.delete();
    end else if (en) begin
      if (full_m) begin
        m_err = 1'b1;
      end else begin
        w.addr = CSR_ADDR_W'(a); w.data = CSR_DATA_W'(d); w.id = CSR_AL_ID_W'(id);
        spec_q.push_back(w);
      end
    end
  endtask

  task automatic idle(input bit rdy);
    step(0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  task automatic drain_all();
    int n = 0;
    while ((exp_q.size() != 0 || csrWrEn_o) && n < 50) begin
      idle(1);
      n++;
    end
    if (n == 50) check("drain_timeout", longint'(exp_q.size()), 0);
    idle(0);
  endtask

  initial begin
    #12;
    check("rst_wr_en", longint'(csrWrEn_o), 0);
    check("rst_addr", longint'(csrWrAddr_o), 0);
    check("rst_data", longint'(csrWrData_o), 0);
    check("rst_full", longint'(full_o), 0);
    check("rst_pending", longint'(pending_o), 0);
    check("rst_err", longint'(err_o), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single write: enqueue, commit, visible next cycle, drain.
    step(1, 'h001, 5, 3, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 3, 0, 0);
    idle(1);
    idle(0);
    idle(0);

    // Flush drops uncommitted 8 and 9; the freed slot takes the next write.
    step(1, 'h010, 70, 7, 0, 0, 0, 0);
    step(1, 'h011, 80, 8, 0, 0, 0, 0);
    step(1, 'h012, 90, 9, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 7, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 'h013, 110, 11, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 11, 0, 1);
    drain_all();

    // Commit and flush together with an enqueue: 7 survives, 10 is dropped silently.
    step(1, 'h020, 77, 7, 0, 0, 0, 0);
    step(1, 'h021, 100, 10, 1, 7, 1, 0);
    drain_all();

    // Randomized traffic without protocol errors.
    for (int i = 0; i < 600; i++) begin
      bit en, cv, fl;
      int unsigned cid = 0;
      fl = ($urandom_range(0, 15) == 0);
      en = $urandom_range(0, 1) && ((spec_q.size() + exp_q.size()) < DEPTH || fl);
      cv = (spec_q.size() != 0) && ($urandom_range(0, 2) != 0);
      if (cv) cid = int'(spec_q[0].id);
      step(en, $urandom_range(0, 7), $urandom, unsigned'(next_id % 32), cv, cid, fl, $urandom_range(0, 1));
      if (en) next_id++;
    end
    step(0, 0, 0, 0, 0, 0, 1, 0);
    drain_all();

    // Wrong tag against speculative head 9: error, cptr holds, correct commit still works.
    step(1, 'h030, 9, 9, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 8, 0, 0);
    idle(0);
    step(0, 0, 0, 0, 1, 9, 0, 0);
    drain_all();

    // Asynchronous reset while committed writes wait to drain.
    step(1, 'h040, 20, 20, 0, 0, 0, 0);
    step(1, 'h041, 21, 21, 1, 20, 0, 0);
    step(0, 0, 0, 0, 1, 21, 0, 0);
    idle(0);
    mon_en = 1'b0;
    #1;
    reset_n = 1'b0;
    csrWrReady_i = 1'b1;
    #1;
    check("mid_rst_wr_en", longint'(csrWrEn_o), 0);
    check("mid_rst_addr", longint'(csrWrAddr_o), 0);
    check("mid_rst_pending", longint'(pending_o), 0);
    check("mid_rst_err", longint'(err_o), 0);
    spec_q.delete();
    exp_q.delete();
    m_err = 1'b0;
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) idle(1);

    // Fill to DEPTH, overflow sets err, then commit with concurrent drain in order 1..4.
    for (int i = 1; i <= 4; i++) step(1, 'h050 + i, 1000 + i, i, 0, 0, 0, 0);
    step(1, 'h055, 1005, 5, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) step(0, 0, 0, 0, 1, i, 0, 1);
    drain_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
